// File: rtl/hex_neighbor_fetch.sv
// Raster-scans a ROWS x COLS hex grid from a synchronous-read RAM and emits centre + six neighbours
// per cell on a valid/ready port. Define HEX_WRAP_EN for a toroidal grid (beta then unused).
module hex_neighbor_fetch #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [17:0]               beta,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [17:0]               mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [17:0]               out_u_curr,
  output logic [17:0]               out_u_nb_0,
  output logic [17:0]               out_u_nb_1,
  output logic [17:0]               out_u_nb_2,
  output logic [17:0]               out_u_nb_3,
  output logic [17:0]               out_u_nb_4,
  output logic [17:0]               out_u_nb_5,
  output logic [$clog2(ROWS)-1:0]   out_row,
  output logic [$clog2(COLS)-1:0]   out_col,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StPresent, StFin} state_e;

  state_e          state_q;
  logic [2:0]      k_q;
  logic [2:0]      rd_k_q;
  logic            rd_vld_q;
  logic [RowW-1:0] r_q;
  logic [ColW-1:0] c_q;
  logic [17:0]     beta_q;
  logic            busy_q;
  logic            done_q;
  logic            out_valid_q;
  logic [17:0]     tap_q [0:6];

  // Neighbour indices always wrap; the has_* flags decide whether a wrapped index is usable.
  logic [RowW-1:0] r_up, r_dn;
  logic [ColW-1:0] c_lf, c_rt;
  logic            has_up, has_dn, has_lf, has_rt;

  assign r_up = (r_q == '0)      ? RowLast : r_q - RowW'(1);
  assign r_dn = (r_q == RowLast) ? '0      : r_q + RowW'(1);
  assign c_lf = (c_q == '0)      ? ColLast : c_q - ColW'(1);
  assign c_rt = (c_q == ColLast) ? '0      : c_q + ColW'(1);

`ifdef HEX_WRAP_EN
  assign has_up = 1'b1;
  assign has_dn = 1'b1;
  assign has_lf = 1'b1;
  assign has_rt = 1'b1;
`else
  assign has_up = (r_q != '0);
  assign has_dn = (r_q != RowLast);
  assign has_lf = (c_q != '0);
  assign has_rt = (c_q != ColLast);
`endif

  logic [RowW-1:0] tap_row;
  logic [ColW-1:0] tap_col;
  logic            tap_in_grid;

  always_comb begin
    tap_row     = r_q;
    tap_col     = c_q;
    tap_in_grid = 1'b1;
    unique case (k_q)
      3'd1: begin tap_row = r_up;                 tap_in_grid = has_up;           end
      3'd2: begin tap_row = r_up; tap_col = c_rt; tap_in_grid = has_up && has_rt; end
      3'd3: begin                 tap_col = c_lf; tap_in_grid = has_lf;           end
      3'd4: begin                 tap_col = c_rt; tap_in_grid = has_rt;           end
      3'd5: begin tap_row = r_dn; tap_col = c_lf; tap_in_grid = has_dn && has_lf; end
      3'd6: begin tap_row = r_dn;                 tap_in_grid = has_dn;           end
      default: ;
    endcase
  end

  assign mem_rd_en   = (state_q == StIssue) && tap_in_grid;
  assign mem_rd_addr = mem_rd_en ? (ADDR_W'(tap_row) * ADDR_W'(COLS) + ADDR_W'(tap_col)) : '0;

  logic last_cell;
  assign last_cell = (r_q == RowLast) && (c_q == ColLast);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      rd_k_q      <= '0;
      rd_vld_q    <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      beta_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 7; i++) tap_q[i] <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      // RAM returns data one cycle after the strobe; route it by the delayed tap index.
      if (rd_vld_q) tap_q[rd_k_q] <= mem_rd_data;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            beta_q  <= beta;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (tap_in_grid) begin
            rd_vld_q <= 1'b1;
            rd_k_q   <= k_q;
          end else begin
            tap_q[k_q] <= beta_q;
          end
          if (k_q == 3'd6) state_q <= StDrain;
          else             k_q     <= k_q + 3'd1;
        end
        StDrain: begin
          out_valid_q <= 1'b1;
          state_q     <= StPresent;
        end
        StPresent: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            k_q         <= '0;
            if (last_cell) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              if (c_q == ColLast) begin
                c_q <= '0;
                r_q <= r_q + RowW'(1);
              end else begin
                c_q <= c_q + ColW'(1);
              end
              state_q <= StIssue;
            end
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out_row    = r_q;
  assign out_col    = c_q;
  assign out_u_curr = tap_q[0];
  assign out_u_nb_0 = tap_q[1];
  assign out_u_nb_1 = tap_q[2];
  assign out_u_nb_2 = tap_q[3];
  assign out_u_nb_3 = tap_q[4];
  assign out_u_nb_4 = tap_q[5];
  assign out_u_nb_5 = tap_q[6];

endmodule

// File: tb/tb_hex_neighbor_fetch.sv
// Scoreboard bench for hex_neighbor_fetch on a 4x4 grid: a grid-level model queues expected
// bundles per scan, a monitor pops them on each handshake and checks timing/read counts.
module tb_hex_neighbor_fetch;
  localparam int R = 4;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [17:0] beta = '0;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [17:0] mem_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_u_curr, nb0, nb1, nb2, nb3, nb4, nb5;
  logic [1:0]  out_row, out_col;
  logic        busy, done;

  logic [17:0]  mem [R*C];
  logic [129:0] expq [$];
  int  tot = 0;
  int  bad = 0;
  int  cyc = 0;
  int  exp_rd = 0;
  bit  ready_rand = 1'b0;

  always #5 clk = ~clk;

  hex_neighbor_fetch #(.ROWS(R), .COLS(C)) dut (
    .clk(clk), .reset(reset), .start(start), .beta(beta),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_u_curr(out_u_curr),
    .out_u_nb_0(nb0), .out_u_nb_1(nb1), .out_u_nb_2(nb2),
    .out_u_nb_3(nb3), .out_u_nb_4(nb4), .out_u_nb_5(nb5),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [129:0] bundle();
    return {out_row, out_col, out_u_curr, nb0, nb1, nb2, nb3, nb4, nb5};
  endfunction

  function automatic logic [137:0] all_outs();
    return {mem_rd_en, mem_rd_addr, out_valid, bundle(), busy, done};
  endfunction

  // Reference: neighbours by row/col offsets on the grid, out-of-grid -> beta (or wrap).
  task automatic build_expected(input logic [17:0] b);
    int dr[6] = '{-1, -1, 0, 0, 1, 1};
    int dc[6] = '{0, 1, -1, 1, -1, 0};
    logic [129:0] w;
    logic [17:0]  v;
    logic [1:0]   rr, cc;
    int nr, nc;
    exp_rd = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        rr = 2'(r);
        cc = 2'(c);
        w = {108'd0, rr, cc, mem[r*C+c]};
        exp_rd++;
        for (int n = 0; n < 6; n++) begin
          nr = r + dr[n];
          nc = c + dc[n];
`ifdef HEX_WRAP_EN
          v = mem[((nr + R) % R) * C + (nc + C) % C];
          exp_rd++;
`else
          if (nr >= 0 && nr < R && nc >= 0 && nc < C) begin
            v = mem[nr*C+nc];
            exp_rd++;
          end else begin
            v = b;
          end
`endif
          w = (w << 18) | {112'd0, v};
        end
        expq.push_back(w);
      end
    end
  endtask

  // Monitor
  bit           scan_on = 1'b0;
  bit           prev_stall = 1'b0;
  bit           prev_busy = 1'b0;
  logic [129:0] prev_b = '0;
  int           t0 = 0;
  int           stalls = 0;
  int           rd_cnt = 0;

  always @(negedge clk) begin
    logic [129:0] cur;
    logic [129:0] e;
    cyc++;
    if (!reset) begin
      scan_on    = 1'b0;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      cur = bundle();
      if (prev_stall) chk("stall_hold", {out_valid, mem_rd_en, cur}, {1'b1, 1'b0, prev_b});
      if (busy && !scan_on) begin
        scan_on = 1'b1;
        t0      = cyc;
        stalls  = 0;
        rd_cnt  = 0;
      end
      if (scan_on) begin
        if (mem_rd_en) rd_cnt++;
        if (out_valid && !out_ready) stalls++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          tot++;
          bad++;
          $display("FAIL unexpected_bundle: got %h want none", cur);
        end else begin
          e = expq.pop_front();
          chk("bundle", cur, e);
        end
      end
      if (done) begin
        chk("done_time", cyc - t0, 144 + stalls);
        chk("busy_fall", {busy, prev_busy}, 2'b01);
        chk("rd_count", rd_cnt, exp_rd);
        chk("queue_empty", expq.size(), 0);
        scan_on = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_b     = cur;
      prev_busy  = busy;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic run_scan(input bit spec_mem, input bit rnd_ready, input int abort_after,
                          output bit hung);
    bit any;
    hung = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < R*C; a++) mem[a] = spec_mem ? 18'(a << 8) : 18'($urandom);
    beta       = spec_mem ? 18'h04000 : 18'($urandom);
    ready_rand = rnd_ready;
    build_expected(beta);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_accept", busy, 1);
    if (abort_after > 0) begin
      start = 1'b0;
      repeat (abort_after) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("reset_clears", all_outs(), 0);
      expq.delete();
      any = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy) any = 1'b1;
      end
      chk("no_done_after_reset", any, 0);
      return;
    end
    hung = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        start = 1'b0;
        hung  = 1'b0;
        break;
      end
      start = 1'($urandom_range(0, 1));  // ignored while busy
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (hung) begin
      tot++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 4000 cycles");
    end
  endtask

  initial begin
    bit hung;
    int cfg_rnd[7]   = '{0, 1, 1, 0, 1, 1, 1};
    int cfg_abort[7] = '{0, 0, 0, 0, 0, 1, 0};
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_state", all_outs(), 0);
    for (int s = 0; s < 7; s++) begin
      run_scan(s == 0, cfg_rnd[s] != 0,
               (cfg_abort[s] != 0) ? int'($urandom_range(20, 120)) : 0, hung);
      if (hung) break;
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
